// File: rtl/blit_pkg.sv
// Shared types and the texture atlas directory for the sprite blitter.
package blit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_PIX  = 2'd3
  } blit_state_t;

  localparam logic [4:0] PIPE_TOP = 5'd0;
  localparam logic [4:0] PIPE_BOT = 5'd1;
  localparam logic [4:0] BIRD0    = 5'd2;
  localparam logic [4:0] BIRD3    = 5'd5;
  localparam logic [4:0] CHAR0    = 5'd6;
  localparam logic [4:0] CHAR23   = 5'd29;

  localparam logic [5:0] TRANSPARENT_KEY = 6'h33;

  typedef struct packed {
    logic        valid;
    logic [15:0] offset;  // in 32-bit words from the atlas base
    logic [5:0]  w;       // pixels, multiple of 4
    logic [7:0]  h;       // rows
  } tex_info_t;

  // Atlas entries are packed back to back in code order: 2 pipes, 4 birds, 24 chars.
  function automatic tex_info_t tex_info(input logic [4:0] code);
    tex_info_t t;
    t = '0;
    if (code <= PIPE_BOT) begin
      t.valid  = 1'b1;
      t.offset = 16'(code) * 16'd1280;
      t.w      = 6'd32;
      t.h      = 8'd160;
    end else if (code <= BIRD3) begin
      t.valid  = 1'b1;
      t.offset = 16'd2560 + 16'(code - BIRD0) * 16'd48;
      t.w      = 6'd16;
      t.h      = 8'd12;
    end else if (code <= CHAR23) begin
      t.valid  = 1'b1;
      t.offset = 16'd2752 + 16'(code - CHAR0) * 16'd16;
      t.w      = 6'd8;
      t.h      = 8'd8;
    end
    return t;
  endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Bundle of command, Avalon read master and draw-buffer write signals.
interface sprite_blitter_if;
  import blit_pkg::*;

  // Command handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
  // the blitter latches cmd_x/cmd_y/cmd_tex on that cycle and raises busy after it.
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [4:0]  cmd_tex;
  logic        busy;

  logic [31:0] master_address;
  logic        master_read;
  logic        master_waitrequest;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;

  logic        fb_we;
  logic [16:0] fb_addr;
  logic [5:0]  fb_data;

  blit_state_t dbg_state;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_tex,
    input  master_waitrequest, master_readdata, master_readdatavalid,
    output cmd_ready, busy, master_address, master_read,
    output fb_we, fb_addr, fb_data, dbg_state
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_tex,
    output master_waitrequest, master_readdata, master_readdatavalid,
    input  cmd_ready, busy, master_address, master_read,
    input  fb_we, fb_addr, fb_data, dbg_state
  );

endinterface

// File: rtl/pix_unpack.sv
// Picks one pixel lane out of a fetched texture word and decides whether it lands on screen.
module pix_unpack
  import blit_pkg::*;
#(
  parameter int         FB_W        = 320,
  parameter int         FB_H        = 240,
  parameter logic [5:0] TRANSPARENT = TRANSPARENT_KEY
) (
  input  logic [23:0] lanes,   // {lane3, lane2, lane1, lane0}, 6 bits each
  input  logic [1:0]  lane,
  input  logic [8:0]  base_x,
  input  logic [7:0]  base_y,
  input  logic [5:0]  col,
  input  logic [7:0]  row,
  output logic [5:0]  pixel,
  output logic        visible,
  output logic [16:0] addr
);

  logic [9:0] px;
  logic [9:0] py;

  always_comb begin
    pixel = 6'd0;
    case (lane)
      2'd0: pixel = lanes[5:0];
      2'd1: pixel = lanes[11:6];
      2'd2: pixel = lanes[17:12];
      2'd3: pixel = lanes[23:18];
      default: pixel = 6'd0;
    endcase
    // 10-bit sums so a sprite hanging past the right/bottom edge never wraps back on screen
    px      = 10'(base_x) + 10'(col) + 10'(lane);
    py      = 10'(base_y) + 10'(row);
    visible = (pixel != TRANSPARENT) && (px < 10'(FB_W)) && (py < 10'(FB_H));
    addr    = 17'(py) * 17'(FB_W) + 17'(px);
  end

endmodule

// File: rtl/sprite_blitter.sv
// Fetches a sprite's texture words over Avalon-MM and writes its visible pixels to the draw buffer.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter logic [31:0] TEX_BASE    = 32'h0800_0000,
  parameter int          FB_W        = 320,
  parameter int          FB_H        = 240,
  parameter logic [5:0]  TRANSPARENT = TRANSPARENT_KEY
) (
  input  logic             clk,
  input  logic             reset,
  sprite_blitter_if.slave  bus
);

  blit_state_t state;
  tex_info_t   cmd_info;

  logic [8:0]  x_q;
  logic [7:0]  y_q;
  logic [5:0]  w_q;
  logic [7:0]  h_q;
  logic [5:0]  col_q;
  logic [7:0]  row_q;
  logic [1:0]  lane_q;
  logic [23:0] lanes_q;
  logic [31:0] addr_q;
  logic        rd_q;
  logic        fb_we_q;
  logic [16:0] fb_addr_q;
  logic [5:0]  fb_data_q;

  logic [5:0]  lane_pix;
  logic        lane_vis;
  logic [16:0] lane_addr;
  logic [5:0]  next_col;
  logic [7:0]  next_row;
  logic        row_done;
  logic        unused_bits;

  assign cmd_info    = tex_info(bus.cmd_tex);
  assign next_col    = col_q + 6'd4;
  assign next_row    = row_q + 8'd1;
  assign row_done    = (next_col == w_q);
  assign unused_bits = ^{bus.master_readdata[31:30], bus.master_readdata[23:22],
                         bus.master_readdata[15:14], bus.master_readdata[7:6]};

  pix_unpack #(
    .FB_W        (FB_W),
    .FB_H        (FB_H),
    .TRANSPARENT (TRANSPARENT)
  ) u_unpack (
    .lanes   (lanes_q),
    .lane    (lane_q),
    .base_x  (x_q),
    .base_y  (y_q),
    .col     (col_q),
    .row     (row_q),
    .pixel   (lane_pix),
    .visible (lane_vis),
    .addr    (lane_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      lane_q    <= '0;
      lanes_q   <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      fb_we_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Unknown texture codes are consumed here without leaving IDLE.
          if (bus.cmd_valid && cmd_info.valid) begin
            x_q    <= bus.cmd_x;
            y_q    <= bus.cmd_y;
            w_q    <= cmd_info.w;
            h_q    <= cmd_info.h;
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= TEX_BASE + {14'd0, cmd_info.offset, 2'b00};
            rd_q   <= 1'b1;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!bus.master_waitrequest) begin
            rd_q  <= 1'b0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.master_readdatavalid) begin
            lanes_q <= {bus.master_readdata[29:24], bus.master_readdata[21:16],
                        bus.master_readdata[13:8],  bus.master_readdata[5:0]};
            lane_q  <= 2'd0;
            state   <= ST_PIX;
          end
        end
        ST_PIX: begin
          fb_we_q   <= lane_vis;
          fb_addr_q <= lane_addr;
          fb_data_q <= lane_pix;
          lane_q    <= lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            if (row_done) begin
              col_q <= '0;
              row_q <= next_row;
            end else begin
              col_q <= next_col;
            end
            if (row_done && (next_row == h_q)) begin
              state <= ST_IDLE;
            end else begin
              addr_q <= addr_q + 32'd4;
              rd_q   <= 1'b1;
              state  <= ST_REQ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = (state == ST_IDLE);
  assign bus.busy           = (state != ST_IDLE);
  assign bus.master_read    = rd_q;
  assign bus.master_address = addr_q;
  assign bus.fb_we          = fb_we_q;
  assign bus.fb_addr        = fb_addr_q;
  assign bus.fb_data        = fb_data_q;
  assign bus.dbg_state      = state;

endmodule
